// File: rtl/contador_m_ud.sv
// Modulo-M up/down counter with load, sync clear and optional saturation.
// Flags: combinational terminal count, half-range, registered tc pulse.
module contador_m_ud #(
  parameter int N      = 4,
  parameter int M      = 16,
  parameter int SATURA = 0
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera_s,
  input  logic         carrega,
  input  logic         conta,
  input  logic         sobe,
  input  logic [N-1:0] D,
  output logic [N-1:0] Q,
  output logic         fim,
  output logic         meio,
  output logic         tc_reg
);

  // Limits are held one bit wider so M = 2^N stays representable.
  localparam logic [N-1:0] MAX  = N'(M - 1);
  localparam logic [N-1:0] ONE  = N'(1);
  localparam logic [N:0]   MOD  = (N+1)'(M);
  localparam logic [N:0]   HALF = (N+1)'(M / 2);
  localparam bit           SAT  = (SATURA != 0);

  logic [N-1:0] q_next;
  logic         at_top;
  logic         at_bot;
  logic         tc_next;

  assign at_top  = (Q == MAX);
  assign at_bot  = (Q == '0);
  assign fim     = conta & (sobe ? at_top : at_bot);
  assign meio    = ({1'b0, Q} >= HALF);
  assign tc_next = fim & ~zera_s & ~carrega;

  always_comb begin
    q_next = Q;
    if (zera_s) begin
      q_next = '0;
    end else if (carrega) begin
      q_next = ({1'b0, D} >= MOD) ? MAX : D;
    end else if (conta) begin
      if (sobe)
        q_next = at_top ? (SAT ? MAX : '0) : Q + ONE;
      else
        q_next = at_bot ? (SAT ? '0 : MAX) : Q - ONE;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      Q      <= '0;
      tc_reg <= 1'b0;
    end else begin
      Q      <= q_next;
      tc_reg <= tc_next;
    end
  end

endmodule
